fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end that consumes the next-PC value produced by the branch unit.
- Owns the architectural PC register and issues word-addressed read requests to instruction memory over a valid/ready channel.
- Buffers in-order responses in a small FIFO and presents {pc, instr} pairs to decode over a valid/ready handshake.
- On redirect, squashes stale in-flight fetches.

Parameters:
- RESET_PC, 32'd0, PC loaded on reset; first fetch address.
- DEPTH, 2, instruction-buffer entries; also the maximum number of outstanding plus buffered fetches.
- CNT_W, 2, width of the occupancy/credit counters; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- redirect_valid  in  1  branch unit requests PC change this cycle
- redirect_pc  in  32  new PC (word address) when redirect_valid
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word address of request
- imem_resp_valid  in  1  response data valid (in order, latency ≥1 cycle)
- imem_resp_data  in  32  instruction word
- out_valid  out  1  buffered instruction available to decode
- out_ready  in  1  decode consumes head entry
- out_pc  out  32  PC of head instruction
- out_instr  out  32  head instruction word

Behaviour:
- Reset (async, immediate):
  - fetch_pc = RESET_PC
  - FIFO empty, outstanding = 0, drop_cnt = 0
  - imem_req_valid = 0, out_valid = 0, out_pc = 0, out_instr = 0
- Request issue:
  - imem_req_valid = 1 when redirect_valid = 0 and (outstanding + fifo_count) < DEPTH.
  - imem_req_addr = fetch_pc.
  - On handshake (valid & ready): push fetch_pc into the pending-PC queue, fetch_pc <= fetch_pc + 1 (mod 2^32, wraps 32'hFFFFFFFF -> 0), outstanding increments.
- Response:
  - Each imem_resp_valid decrements outstanding.
  - If drop_cnt > 0: discard the response, drop_cnt decrements, pop the pending-PC queue.
  - Otherwise: write {pending head PC, imem_resp_data} into the FIFO and pop the pending queue.
  - Credit rule guarantees the FIFO is never full on an accepted response.
  - A response arriving with outstanding = 0 is a protocol error and is ignored.
- Output:
  - out_valid = FIFO non-empty; out_pc/out_instr = head, registered.
  - Head pops on out_valid & out_ready.
  - Data stays stable while out_valid & !out_ready.
- Redirect (priority over everything else in the same cycle):
  - fetch_pc <= redirect_pc.
  - FIFO flushed; out_valid = 0 next cycle.
  - drop_cnt <= outstanding minus (1 if a response arrives this cycle).
  - Any response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
  - An out_ready pop in the redirect cycle is a no-op.
  - The first request to redirect_pc issues the next cycle if credits allow.
- Simultaneous events:
  - Push and pop in the same cycle keep the count unchanged.
  - Request handshake and response in the same cycle keep outstanding unchanged.
- Back-to-back redirects: the last one wins; drop_cnt recomputed each time.
- Throughput: sustained 1 instr/cycle with 1-cycle memory latency and DEPTH = 2.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetched[31:0] (count of instructions popped to decode) and perf_squashed[31:0] (count of discarded responses plus flushed FIFO entries). Both reset to 0, saturate at 32'hFFFFFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- fetch_pkg holds:
  - XLEN = 32, default RESET_PC constant
  - fetch_entry_t struct {pc[31:0], instr[31:0]}
  - credit/count width constant
- Sub-module fetch_fifo: parameterised synchronous FIFO with DEPTH, push, pop, flush, count, head. Instantiated twice:
  - pending-PC queue
  - instruction buffer

Test Plan:
- Reset with RESET_PC = 0, imem ready, 1-cycle latency, out_ready = 1 -> addresses 0,1,2,3 issued on consecutive cycles; out_pc 0,1,2,3 with matching instr.
- out_ready = 0 for 5 cycles -> exactly 2 requests issued, out_valid = 1, out_pc = 0 held stable; resumes at addr 2 when out_ready rises.
- Redirect to 32'h40 with 2 requests outstanding (addr 5, 6) -> both responses dropped; next out_pc = 32'h40; no request in the redirect cycle.
- Redirect in the same cycle as a response and as out_ready -> response discarded, drop_cnt = outstanding − 1, FIFO empty next cycle.
- fetch_pc = 32'hFFFFFFFF -> next request address 32'h0.
- rst asserted mid-stream with 2 outstanding -> immediately out_valid = 0, imem_req_valid = 0; after release, fetch restarts at RESET_PC and late responses are ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Optional performance counters are enabled with the FETCH_PERF_EN macro.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'd0;
  localparam int DEPTH_DEFAULT = 2;
  // Occupancy/credit counter width; 2**CNT_W must exceed DEPTH.
  localparam int CNT_W_DEFAULT = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Saturating accumulate used by the optional counters.
  function automatic logic [XLEN-1:0] sat_add(input logic [XLEN-1:0] v,
                                              input logic [XLEN-1:0] d);
    logic [XLEN:0] sum;
    sum = {1'b0, v} + {1'b0, d};
    return sum[XLEN] ? {XLEN{1'b1}} : sum[XLEN-1:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush. The head is read straight from the
// entry registers, so it is glitch-free and stable while nothing pops.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int WIDTH = XLEN,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] entries [DEPTH];
  logic             push_en;
  logic             pop_en;

  // Never pop an empty FIFO or overwrite a full one.
  assign pop_en  = pop & (count_reg != '0);
  assign push_en = push & (count_reg != CNT_W'(DEPTH)) & ~flush;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] data_reg;
    // Capture push data when the write pointer selects this slot.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        data_reg <= '0;
      else if (push_en && (wr_ptr_reg == PTR_W'(gi)))
        data_reg <= push_data;
    end
    assign entries[gi] = data_reg;
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_en)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  assign count = count_reg;
  assign head  = entries[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word-addressed fetches,
// tags in-order responses with their PC and buffers them for decode.
// Redirects flush the buffer and squash fetches still in flight.
// Optional: define FETCH_PERF_EN for perf_fetched / perf_squashed counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = DEPTH_DEFAULT,
  parameter int              CNT_W    = CNT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_squashed
`endif
);

  logic [XLEN-1:0]  fetch_pc_reg;
  logic [CNT_W-1:0] drop_cnt_reg;
  logic [CNT_W-1:0] pend_count;   // equals the number of outstanding fetches
  logic [CNT_W-1:0] buf_count;
  logic [XLEN-1:0]  pend_head;
  fetch_entry_t     buf_head;
  fetch_entry_t     buf_push_data;
  logic [CNT_W:0]   in_use;
  logic             pop_fire;
  logic             req_fire;
  logic             resp_acc;
  logic             resp_keep;

  // A head pop this cycle frees a slot, which keeps 1 instr/cycle streaming
  // with single-cycle memory and a two-entry buffer.
  assign pop_fire       = (buf_count != '0) & out_ready & ~redirect_valid;
  assign in_use         = {1'b0, pend_count} + {1'b0, buf_count} - (CNT_W+1)'(pop_fire);
  assign imem_req_valid = ~rst & ~redirect_valid & (in_use < (CNT_W+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Responses with nothing outstanding are stray and ignored entirely.
  assign resp_acc      = imem_resp_valid & (pend_count != '0);
  assign resp_keep     = resp_acc & ~redirect_valid & (drop_cnt_reg == '0);
  assign buf_push_data = '{pc: pend_head, instr: imem_resp_data};

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN), .CNT_W(CNT_W)) u_pend_q (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (fetch_pc_reg),
    .pop       (resp_acc),
    .flush     (1'b0),
    .count     (pend_count),
    .head      (pend_head)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t)), .CNT_W(CNT_W)) u_ibuf (
    .clk       (clk),
    .rst       (rst),
    .push      (resp_keep),
    .push_data (buf_push_data),
    .pop       (pop_fire),
    .flush     (redirect_valid),
    .count     (buf_count),
    .head      (buf_head)
  );

  // PC advance and squash accounting; a redirect overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      drop_cnt_reg <= '0;
    end else if (redirect_valid) begin
      fetch_pc_reg <= redirect_pc;
      drop_cnt_reg <= pend_count - CNT_W'(resp_acc);
    end else begin
      if (req_fire)
        fetch_pc_reg <= fetch_pc_reg + 32'd1;
      if (resp_acc && (drop_cnt_reg != '0))
        drop_cnt_reg <= drop_cnt_reg - CNT_W'(1);
    end
  end

  assign out_valid = (buf_count != '0);
  assign out_pc    = buf_head.pc;
  assign out_instr = buf_head.instr;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_squashed_reg;
  logic [31:0] squash_now;

  assign squash_now = (redirect_valid ? 32'(buf_count) : 32'd0) + 32'(resp_acc & ~resp_keep);

  // Saturating counts of delivered and discarded instructions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_reg  <= '0;
      perf_squashed_reg <= '0;
    end else begin
      perf_fetched_reg  <= sat_add(perf_fetched_reg, 32'(pop_fire));
      perf_squashed_reg <= sat_add(perf_squashed_reg, squash_now);
    end
  end

  assign perf_fetched  = perf_fetched_reg;
  assign perf_squashed = perf_squashed_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a stream-level model (expected next request PC and
// expected next delivered PC, both reset/redirect driven) checked every cycle,
// plus directed literal expectations for each scenario.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RPC = 32'd0;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(2), .CNT_W(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_squashed   (perf_squashed)
`endif
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [31:0] exp_req_pc;
  logic [31:0] exp_out_pc;
  bit          expect_empty;
  bit          expect_hold;
  bit          mem_hold;
  bit          last_hs;
  logic [31:0] last_hs_addr;
  logic [31:0] mem_q [$];
  logic [31:0] req_log [$];
  logic [31:0] req_cyc [$];
  logic [31:0] out_log [$];
  logic [31:0] out_cyc [$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h0101_0101) ^ 32'hCAFE_F00D;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q [$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic clear_logs();
    req_log.delete(); req_cyc.delete(); out_log.delete(); out_cyc.delete();
  endtask

  // Per-cycle comparison against the stream model, sampled before the edge.
  task automatic check_cycle();
    last_hs = 1'b0;
    if (expect_empty) chk("flush_empty", 32'(out_valid), 32'd0);
    if (expect_hold)  chk("stall_valid", 32'(out_valid), 32'd1);
    expect_empty = 1'b0;
    expect_hold  = 1'b0;
    if (redirect_valid) begin
      chk("redir_no_req", 32'(imem_req_valid), 32'd0);
      exp_req_pc   = redirect_pc;
      exp_out_pc   = redirect_pc;
      expect_empty = 1'b1;
    end else begin
      if (imem_req_valid) begin
        chk("req_addr", imem_req_addr, exp_req_pc);
        if (imem_req_ready) begin
          last_hs      = 1'b1;
          last_hs_addr = imem_req_addr;
          req_log.push_back(imem_req_addr);
          req_cyc.push_back(32'(cyc));
          exp_req_pc++;
        end
      end
      if (out_valid) begin
        chk("out_pc", out_pc, exp_out_pc);
        chk("out_instr", out_instr, instr_of(exp_out_pc));
        if (out_ready) begin
          out_log.push_back(out_pc);
          out_cyc.push_back(32'(cyc));
          exp_out_pc++;
        end else begin
          expect_hold = 1'b1;
        end
      end
    end
  endtask

  // One clock cycle: memory answers one cycle after acceptance unless held.
  task automatic step();
    if (!mem_hold && mem_q.size() > 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = instr_of(mem_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #4;
    check_cycle();
    @(posedge clk);
    cyc++;
    if (last_hs) mem_q.push_back(last_hs_addr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    repeat (2) @(negedge clk);
    rst          = 1'b0;
    exp_req_pc   = RPC;
    exp_out_pc   = RPC;
    expect_empty = 1'b0;
    expect_hold  = 1'b0;
    mem_hold     = 1'b0;
    mem_q.delete();
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    out_ready = 1'b1; mem_hold = 1'b0;
    @(negedge clk);

    // Streaming: consecutive addresses and consecutive deliveries.
    do_reset();
    repeat (8) step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_req_addr%0d", i), qget(req_log, i), 32'(i));
      chk($sformatf("t1_out_pc%0d", i), qget(out_log, i), 32'(i));
    end
    chk("t1_req_back_to_back", qget(req_cyc, 3) - qget(req_cyc, 0), 32'd3);
    chk("t1_out_back_to_back", qget(out_cyc, 3) - qget(out_cyc, 0), 32'd3);

    // Decode stall: only two fetches may be in the system.
    do_reset();
    out_ready = 1'b0;
    repeat (5) step();
    chk("t2_req_count", 32'(req_log.size()), 32'd2);
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_out_pc", out_pc, 32'd0);
    out_ready = 1'b1;
    clear_logs();
    repeat (3) step();
    chk("t2_resume_addr", qget(req_log, 0), 32'd2);

    // Redirect with addresses 5 and 6 still outstanding.
    do_reset();
    for (int i = 0; i < 20 && !(last_hs && last_hs_addr == 32'd5); i++) step();
    mem_hold = 1'b1;
    repeat (2) step();
    chk("t3_outstanding", 32'(mem_q.size()), 32'd2);
    chk("t3_pending0", qget(mem_q, 0), 32'd5);
    chk("t3_pending1", qget(mem_q, 1), 32'd6);
    clear_logs();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0; mem_hold = 1'b0;
    repeat (8) step();
    chk("t3_first_req", qget(req_log, 0), 32'h40);
    chk("t3_first_out", qget(out_log, 0), 32'h40);

    // Redirect coinciding with a response and a decode pop.
    for (int i = 0; i < 10 && !(mem_q.size() > 0 && out_valid); i++) step();
    chk("t4_pre_valid", 32'(out_valid), 32'd1);
    clear_logs();
    redirect_valid = 1'b1; redirect_pc = 32'h80; out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    repeat (6) step();
    chk("t4_first_req", qget(req_log, 0), 32'h80);
    chk("t4_first_out", qget(out_log, 0), 32'h80);

    // Back-to-back redirects: the later target wins.
    clear_logs();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    repeat (8) step();
    chk("t4b_first_req", qget(req_log, 0), 32'h200);
    chk("t4b_first_out", qget(out_log, 0), 32'h200);

    // PC wrap at the top of the address space.
    clear_logs();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    repeat (8) step();
    chk("t5_req0", qget(req_log, 0), 32'hFFFF_FFFF);
    chk("t5_req1", qget(req_log, 1), 32'h0);
    chk("t5_out1", qget(out_log, 1), 32'h0);

    // Asynchronous reset mid-stream, then a stray late response.
    repeat (6) step();
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    imem_resp_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_async_out_valid", 32'(out_valid), 32'd0);
    chk("t6_async_req_valid", 32'(imem_req_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_req_pc = RPC; exp_out_pc = RPC;
    expect_empty = 1'b0; expect_hold = 1'b0; mem_hold = 1'b0;
    clear_logs();
    imem_req_ready = 1'b0;
    step();
    mem_q.delete();
    imem_req_ready = 1'b1;
    repeat (6) step();
    chk("t6_restart_req", qget(req_log, 0), RPC);
    chk("t6_restart_out", qget(out_log, 0), RPC);
    chk("t6_restart_instr", out_log.size() > 0 ? instr_of(qget(out_log, 0)) : 32'h0, instr_of(RPC));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
